// File: rtl/div_share_pkg.sv
// rtl/div_share_pkg.sv - shared types, defaults and round-robin pick for div_share_arb
package div_share_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREQ  = 4;
    localparam int MAX_NREQ  = 32;

    // First valid requester after 'last', wrapping modulo nreq; -1 when none is valid.
    function automatic int rr_next_grant(input logic [MAX_NREQ-1:0] valid,
                                         input int nreq, input int last);
        int idx;
        int pick;
        pick = -1;
        for (int k = 1; k <= MAX_NREQ; k++) begin
            if (k <= nreq && pick < 0) begin
                idx = last + k;
                if (idx >= nreq) idx = idx - nreq;
                if (valid[idx]) pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/div_seq_core.sv
// rtl/div_seq_core.sv - WIDTH-cycle restoring divider, one quotient bit per cycle
module div_seq_core
    import div_share_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] src_rem, src_quo, src_div;
    logic [WIDTH:0]   rem_sh, rem_sub;

    // The first iteration is folded into the start cycle so the result lands after WIDTH edges.
    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? a  : quo_q;
        src_div = start ? b  : div_q;
        rem_sh  = {src_rem, src_quo[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, src_div};
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        if (start || cnt_q != '0) begin
            div_d = src_div;
            if (rem_sh >= {1'b0, src_div}) begin
                rem_d = rem_sub[WIDTH-1:0];
                quo_d = {src_quo[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[WIDTH-1:0];
                quo_d = {src_quo[WIDTH-2:0], 1'b0};
            end
            if (start) begin
                cnt_d  = CW'(WIDTH - 1);
                done_d = 1'b0;
            end else begin
                cnt_d  = cnt_q - CW'(1);
                done_d = (cnt_q == CW'(1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign q    = quo_q;
    assign r    = rem_q;

endmodule

// File: rtl/div_share_arb.sv
// rtl/div_share_arb.sv - round-robin sharing of one divider; DIV_ZERO_TRAP_EN enables 1-cycle b==0 trap
module div_share_arb
    import div_share_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_q,
    output logic [WIDTH-1:0]      rsp_r,
    output logic                  rsp_err,
    output logic                  busy
);

    state_e               state_q, state_d;
    logic [IDW-1:0]       last_q, last_d, id_q, id_d, gidx;
    logic [WIDTH-1:0]     q_q, q_d, r_q, r_d, ga, gb, core_q, core_r;
    logic                 core_start, core_done, gvalid;
    logic [MAX_NREQ-1:0]  valid_ext;
    int                   pick;
`ifdef DIV_ZERO_TRAP_EN
    logic                 err_q, err_d;
`endif

    always_comb begin
        valid_ext = '0;
        valid_ext[NREQ-1:0] = req_valid;
        pick       = rr_next_grant(valid_ext, NREQ, int'(last_q));
        gvalid     = (pick >= 0);
        gidx       = pick[IDW-1:0];
        ga         = req_a[gidx*WIDTH +: WIDTH];
        gb         = req_b[gidx*WIDTH +: WIDTH];
        req_ready  = '0;
        core_start = 1'b0;
        state_d    = state_q;
        last_d     = last_q;
        id_d       = id_q;
        q_d        = q_q;
        r_d        = r_q;
`ifdef DIV_ZERO_TRAP_EN
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (gvalid) begin
                    req_ready[gidx] = 1'b1;
                    last_d          = gidx;
                    id_d            = gidx;
`ifdef DIV_ZERO_TRAP_EN
                    if (gb == '0) begin
                        state_d = DONE;
                        q_d     = '1;
                        r_d     = ga;
                        err_d   = 1'b1;
                    end else begin
                        core_start = 1'b1;
                        state_d    = CALC;
                        err_d      = 1'b0;
                    end
`else
                    core_start = 1'b1;
                    state_d    = CALC;
`endif
                end
            end
            CALC: begin
                if (core_done) begin
                    state_d = DONE;
                    q_d     = core_q;
                    r_d     = core_r;
                end
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= IDW'(NREQ - 1);
            id_q    <= '0;
            q_q     <= '0;
            r_q     <= '0;
`ifdef DIV_ZERO_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            q_q     <= q_d;
            r_q     <= r_d;
`ifdef DIV_ZERO_TRAP_EN
            err_q   <= err_d;
`endif
        end
    end

    div_seq_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (core_start),
        .a     (ga),
        .b     (gb),
        .done  (core_done),
        .q     (core_q),
        .r     (core_r)
    );

    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = id_q;
    assign rsp_q     = q_q;
    assign rsp_r     = r_q;
`ifdef DIV_ZERO_TRAP_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_div_share_arb.sv
// tb/tb_div_share_arb.sv - directed self-checking bench for div_share_arb
module tb_div_share_arb;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
`ifdef DIV_ZERO_TRAP_EN
    localparam int ZLAT = 1;
    localparam logic ZERR = 1'b1;
`else
    localparam int ZLAT = 33;
    localparam logic ZERR = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_q, rsp_r;
    logic                  rsp_err, busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
        req_valid[id] = 1'b1;
    endtask

    // Leaves the caller 1 time unit after the handshake edge.
    task automatic do_req(input int id, input logic [31:0] a, input logic [31:0] b);
        int t = 0;
        @(negedge clk);
        set_req(id, a, b);
        #1;
        while (!req_ready[id] && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("grant_wait", 64'(t < 100), 1);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 1;
        while (!rsp_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic take_rsp(input string tag, input int id, input logic [31:0] q,
                            input logic [31:0] r, input logic err);
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_id"}, rsp_id, id);
        check({tag, "_q"}, rsp_q, q);
        check({tag, "_r"}, rsp_r, r);
        check({tag, "_err"}, rsp_err, err);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int cyc;
        int bad;
        int t;
        logic [31:0] sq, sr;

        do_reset();
        #1;
        check("rst_valid", rsp_valid, 0);
        check("rst_q", rsp_q, 0);
        check("rst_r", rsp_r, 0);
        check("rst_id", rsp_id, 0);
        check("rst_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);

        // single op with latency
        do_req(1, 100, 7);
        check("single_busy", busy, 1);
        wait_rsp(cyc);
        check("single_lat", cyc, 33);
        take_rsp("single", 1, 14, 2, 1'b0);

        // contention after reset: grants in ID order
        do_reset();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(1000 + i), 10);
        #1;
        for (int k = 0; k < NREQ; k++) begin
            int g = 0;
            t = 0;
            while (req_ready == '0 && t < 100) begin
                @(negedge clk);
                #1;
                t++;
            end
            check("cont_ready", req_ready, 64'(1) << k);
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
            @(posedge clk);
            #1;
            req_valid[g] = 1'b0;
            check("cont_calc_ready", req_ready, 0);
            wait_rsp(cyc);
            check("cont_lat", cyc, 33);
            take_rsp("cont", k, 100, 32'(k), 1'b0);
        end

        // backpressure in DONE with a competing request pending
        do_req(2, 5, 9);
        wait_rsp(cyc);
        check("bp_lat", cyc, 33);
        sq = rsp_q;
        sr = rsp_r;
        check("small_q", sq, 0);
        check("small_r", sr, 5);
        check("small_id", rsp_id, 2);
        set_req(0, 32'hFFFF_FFFF, 1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (!rsp_valid || rsp_q !== sq || rsp_r !== sr || rsp_id !== 2'd2 || req_ready !== '0)
                bad++;
        end
        check("bp_stable", bad, 0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("bp_release_idle", busy, 0);
        check("bp_next_ready", req_ready, 4'b0001);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        check("max_busy", busy, 1);
        wait_rsp(cyc);
        take_rsp("max", 0, 32'hFFFF_FFFF, 0, 1'b0);

        // divide by zero
        do_req(3, 42, 0);
        wait_rsp(cyc);
        check("dz_lat", cyc, ZLAT);
        take_rsp("dz", 3, 32'hFFFF_FFFF, 42, ZERR);

        // reset mid-CALC
        do_req(3, 77, 3);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_q", rsp_q, 0);
        check("mid_rst_r", rsp_r, 0);
        check("mid_rst_id", rsp_id, 0);
        check("mid_rst_err", rsp_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid[3] = 1'b1;
        req_valid[0] = 1'b1;
        #1;
        check("post_rst_grant", req_ready, 4'b0001);
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
